// File: rtl/joy_pkg.sv
// Shared constants for the joystick front end: line order within a
// port, lines per port, and the debounce counter width helper.
package joy_pkg;

  localparam int JOY_FIRE  = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_RIGHT = 2;
  localparam int JOY_DOWN  = 3;
  localparam int JOY_UP    = 4;
  localparam int JOY_LINES = 5;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// One joystick line: synchroniser, polarity normalisation and debouncer.
// Ports: clk, rst_n, pin (raw level), pressed (debounced, 1 = pressed).
module joy_debounce
  import joy_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit ACTIVE_LOW_IN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic pressed
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic REL = ACTIVE_LOW_IN;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= {SYNC_STAGES{REL}};
    else        sync <= {sync[SYNC_STAGES-2:0], pin};
  end

  assign synced = sync[SYNC_STAGES-1] ^ REL;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement with the stable state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (synced == pressed) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      pressed <= synced;
      cnt     <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/joystick_ports.sv
// Atari-style joystick front end: per-line debounce, per-port SOCD and
// optional autofire (macro JOYSTICK_AUTOFIRE_EN), port swap, registered out.
// Ports: clk, rst_n, pin_in, port_swap, autofire_sel -> joy_out,
// change_strobe, change_port.
module joystick_ports
  import joy_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit ACTIVE_LOW_IN   = 1'b1,
  parameter bit SOCD_NEUTRAL    = 1'b1,
  parameter int AUTOFIRE_PERIOD = 2000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*JOY_LINES-1:0] pin_in,
  input  logic                           port_swap,
  input  logic [NUM_PORTS-1:0]           autofire_sel,
  output logic [NUM_PORTS*JOY_LINES-1:0] joy_out,
  output logic                           change_strobe,
  output logic [1:0]                     change_port
);

  localparam int W = NUM_PORTS * JOY_LINES;

  logic [W-1:0] stable;
  logic [W-1:0] socd;
  logic [W-1:0] fired;
  logic [W-1:0] muxed;
  logic [W-1:0] diff;
  logic [1:0]   low;

  for (genvar g = 0; g < W; g++) begin : g_line
    joy_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW_IN  (ACTIVE_LOW_IN)
    ) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin    (pin_in[g]),
      .pressed(stable[g])
    );
  end

  always_comb begin
    socd = stable;
    if (SOCD_NEUTRAL) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (stable[p*JOY_LINES+JOY_LEFT] &&
            stable[p*JOY_LINES+JOY_RIGHT]) begin
          socd[p*JOY_LINES+JOY_LEFT]  = 1'b0;
          socd[p*JOY_LINES+JOY_RIGHT] = 1'b0;
        end
        if (stable[p*JOY_LINES+JOY_UP] &&
            stable[p*JOY_LINES+JOY_DOWN]) begin
          socd[p*JOY_LINES+JOY_UP]   = 1'b0;
          socd[p*JOY_LINES+JOY_DOWN] = 1'b0;
        end
      end
    end
  end

`ifdef JOYSTICK_AUTOFIRE_EN
  localparam int AW = cnt_width(AUTOFIRE_PERIOD);
  localparam logic [AW-1:0] AF_LAST = AW'(AUTOFIRE_PERIOD - 1);

  logic [AW-1:0] af_cnt;
  logic          phase;

  // Free-running; releasing fire does not restart the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_cnt <= '0;
      phase  <= 1'b0;
    end else if (af_cnt == AF_LAST) begin
      af_cnt <= '0;
      phase  <= ~phase;
    end else begin
      af_cnt <= af_cnt + AW'(1);
    end
  end

  always_comb begin
    fired = socd;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (autofire_sel[p] && socd[p*JOY_LINES+JOY_FIRE])
        fired[p*JOY_LINES+JOY_FIRE] = phase;
    end
  end
`else
  logic unused_sel;
  assign unused_sel = ^autofire_sel;
  assign fired      = socd;
`endif

  if (NUM_PORTS > 1) begin : g_swap
    always_comb begin
      muxed = fired;
      if (port_swap) begin
        muxed[0 +: JOY_LINES]         = fired[JOY_LINES +: JOY_LINES];
        muxed[JOY_LINES +: JOY_LINES] = fired[0 +: JOY_LINES];
      end
    end
  end else begin : g_noswap
    logic unused_swap;
    assign unused_swap = port_swap;
    assign muxed       = fired;
  end

  assign diff = muxed ^ joy_out;

  // Scan downward so the lowest changed port wins.
  always_comb begin
    low = 2'd0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (|diff[p*JOY_LINES +: JOY_LINES]) low = 2'(p);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy_out       <= '0;
      change_strobe <= 1'b0;
      change_port   <= 2'd0;
    end else begin
      joy_out       <= muxed;
      change_strobe <= |diff;
      if (|diff) change_port <= low;
    end
  end

endmodule

// File: tb/tb_joystick_ports.sv
// Self-checking bench for joystick_ports: a history-window reference model
// compared every cycle, plus directed checks with literal expectations.
module tb_joystick_ports;

  localparam int NP = 2;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int P  = 8;
  localparam int W  = NP * 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  pin_in;
  logic          port_swap;
  logic [NP-1:0] autofire_sel;
  logic [W-1:0]  joy_out;
  logic          change_strobe;
  logic [1:0]    change_port;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  joystick_ports #(
    .NUM_PORTS      (NP),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW_IN  (1'b1),
    .SOCD_NEUTRAL   (1'b1),
    .AUTOFIRE_PERIOD(P)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pin_in       (pin_in),
    .port_swap    (port_swap),
    .autofire_sel (autofire_sel),
    .joy_out      (joy_out),
    .change_strobe(change_strobe),
    .change_port  (change_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a line's stable state flips once the pressed level seen
  // after the synchroniser has disagreed with it for D edges in a row.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable;
  logic [W-1:0] m_out;
  logic         m_strobe;
  logic [1:0]   m_port;
  int           m_edges;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + D; i++) hist.push_back('0);
    m_stable = '0;
    m_out    = '0;
    m_strobe = 1'b0;
    m_port   = 2'd0;
    m_edges  = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] v;
    bit           all;
    hist.push_front(~pin_in);
    void'(hist.pop_back());
    v = m_stable;
    for (int p = 0; p < NP; p++) begin
      if (m_stable[p*5+1] && m_stable[p*5+2]) begin
        v[p*5+1] = 1'b0;
        v[p*5+2] = 1'b0;
      end
      if (m_stable[p*5+3] && m_stable[p*5+4]) begin
        v[p*5+3] = 1'b0;
        v[p*5+4] = 1'b0;
      end
    end
`ifdef JOYSTICK_AUTOFIRE_EN
    for (int p = 0; p < NP; p++)
      if (autofire_sel[p] && v[p*5]) v[p*5] = ((m_edges / P) % 2) == 1;
`endif
    if (port_swap) v = {v[4:0], v[9:5]};
    m_strobe = (v != m_out);
    if (m_strobe) m_port = (v[4:0] != m_out[4:0]) ? 2'd0 : 2'd1;
    m_out = v;
    for (int b = 0; b < W; b++) begin
      all = 1;
      for (int k = S; k < S + D; k++)
        if (hist[k][b] == m_stable[b]) all = 0;
      if (all) m_stable[b] = ~m_stable[b];
    end
    m_edges++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_joy_out", 32'(joy_out), 32'(m_out));
      chk("model_strobe", 32'(change_strobe), 32'(m_strobe));
      if (m_strobe) chk("model_port", 32'(change_port), 32'(m_port));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int tog;
  logic prev;

  initial begin
    rst_n        = 1'b0;
    pin_in       = '1;
    port_swap    = 1'b0;
    autofire_sel = '0;
    cyc(1);
    cmp_en = 1;
    cyc(2);
    chk("reset_joy", 32'(joy_out), 0);
    chk("reset_strobe", 32'(change_strobe), 0);
    chk("reset_port", 32'(change_port), 0);
    rst_n = 1'b1;
    cyc(10);
    chk("idle_joy", 32'(joy_out), 0);

    pin_in[4] = 1'b0;
    cyc(6);
    chk("up_edge6", 32'(joy_out), 0);
    cyc(1);
    chk("up_edge7", 32'(joy_out), 32'h010);
    chk("up_strobe", 32'(change_strobe), 1);
    chk("up_port", 32'(change_port), 0);
    cyc(1);
    chk("up_strobe_once", 32'(change_strobe), 0);
    pin_in[4] = 1'b1;
    cyc(10);
    chk("up_release", 32'(joy_out), 0);

    pin_in[5] = 1'b0;
    cyc(3);
    pin_in[5] = 1'b1;
    cyc(12);
    chk("glitch3", 32'(joy_out), 0);

    pin_in[5] = 1'b0;
    cyc(4);
    pin_in[5] = 1'b1;
    cyc(3);
    chk("glitch4", 32'(joy_out), 32'h020);
    cyc(10);
    chk("glitch4_rel", 32'(joy_out), 0);

    pin_in[1] = 1'b0;
    pin_in[2] = 1'b0;
    cyc(12);
    chk("socd_lr", 32'(joy_out), 0);
    pin_in[2] = 1'b1;
    cyc(12);
    chk("socd_left", 32'(joy_out), 32'h002);
    pin_in[1] = 1'b1;
    cyc(12);
    chk("socd_rel", 32'(joy_out), 0);

    pin_in[0] = 1'b0;
    cyc(12);
    chk("fire0", 32'(joy_out), 32'h001);
    port_swap = 1'b1;
    cyc(1);
    chk("swap_joy", 32'(joy_out), 32'h020);
    chk("swap_strobe", 32'(change_strobe), 1);
    chk("swap_port", 32'(change_port), 0);
    port_swap = 1'b0;
    cyc(1);
    chk("unswap_joy", 32'(joy_out), 32'h001);
    pin_in[0] = 1'b1;
    cyc(12);

    pin_in[9] = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    cyc(2);
    chk("rst_mid", 32'(joy_out), 0);
    rst_n = 1'b1;
    cyc(6);
    chk("rst_edge6", 32'(joy_out), 0);
    cyc(1);
    chk("rst_edge7", 32'(joy_out), 32'h200);
    chk("rst_port", 32'(change_port), 1);
    pin_in[8] = 1'b0;
    cyc(12);
    chk("socd_ud", 32'(joy_out), 0);
    pin_in[9:8] = 2'b11;
    cyc(12);

`ifdef JOYSTICK_AUTOFIRE_EN
    autofire_sel = 2'b01;
    pin_in[0]    = 1'b0;
    cyc(12);
    tog  = 0;
    prev = joy_out[0];
    repeat (32) begin
      cyc(1);
      if (joy_out[0] != prev) tog++;
      prev = joy_out[0];
    end
    chk("af_toggles", 32'(tog), 4);
    pin_in[0] = 1'b1;
    cyc(12);
    chk("af_release", 32'(joy_out[0]), 0);
`endif

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
